beta_skid_pipe: RTL and testbench
=================================

Name: beta_skid_pipe

Overview:
Parametrised inter-stage pipeline register for the beta core. It supersedes the fixed-field stall/flush registers with one generic payload slot and a valid/ready handshake. An optional second "skid" entry registers the upstream ready, which breaks the combinational ready path between stages while keeping full throughput. It also produces a non-stallable one-cycle new-instruction pulse and reports its occupancy.

Parameters:
DataWidth, 32, payload width in bits (the packed stage bundle: control word, operands, offsets, pc, rd).
SkidEnable, 1, 1 = two-entry skid (pip_ready_o registered); 0 = single entry (pip_ready_o combinational).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous reset, active-high
pip_valid_i  in  1  upstream item valid
pip_ready_o  out  1  block can accept an item this cycle
pip_data_i  in  DataWidth  upstream payload
pip_valid_o  out  1  downstream item valid
pip_ready_i  in  1  downstream accepts this cycle
pip_data_o  out  DataWidth  head payload
pip_flush_i  in  1  synchronous flush from the Pipeline Control Unit
pip_new_instr_o  out  1  one-cycle pulse in the first cycle a new item is at the head
pip_occupancy_o  out  2  number of held items (0..2)

Behaviour:
- Reset (async, active-high, takes effect immediately): state EMPTY; main and skid data = 0; pip_valid_o=0, pip_data_o=0, pip_new_instr_o=0, pip_occupancy_o=0. pip_ready_o=0 while rst_i is high, and 1 in the first cycle after release. Reset mid-transfer drops every held item; no partial state survives.
- Transfers: in_fire = pip_valid_i & pip_ready_o; out_fire = pip_valid_o & pip_ready_i.
- pip_valid_o = (state != EMPTY). pip_data_o = main register, which is 0 when EMPTY.
- States: EMPTY, FULL (main held), SKID (main + skid held; only when SkidEnable=1).
- EMPTY: in_fire -> main<=data_i, go to FULL.
- FULL, in_fire & out_fire -> main<=data_i, stay FULL.
- FULL, in_fire & !out_fire -> skid<=data_i, go to SKID (SkidEnable=1 only).
- FULL, !in_fire & out_fire -> main<=0, go to EMPTY.
- FULL, no transfer -> hold.
- SKID: pip_ready_o=0. On out_fire, main<=skid, skid<=0, go to FULL. Otherwise hold.
- SkidEnable=1: pip_ready_o = (state != SKID), driven from state flops only and independent of pip_ready_i.
- SkidEnable=0: pip_ready_o = (state==EMPTY) | pip_ready_i (combinational). The SKID state is unreachable and occupancy never exceeds 1.
- Latency: an item accepted at edge N is on pip_data_o with pip_valid_o=1 after edge N (1 cycle). Throughput is 1 item/cycle while the downstream is ready.
- Ordering is strict FIFO: main always holds the older item.
- Flush (pip_flush_i=1 at an edge) has highest priority. State goes to EMPTY, all data registers clear to 0, pip_new_instr_o goes to 0, and any in_fire in the same cycle is discarded. The upstream must treat a flush-cycle handshake as killed. Flush combined with out_fire still counts as delivered downstream.
- pip_new_instr_o is registered. It is 1 in exactly the cycle after main is loaded with a new item: EMPTY->FULL load, FULL pass-through load, or SKID->FULL promotion. It is never extended by a downstream stall (pip_ready_i=0) and is never asserted in an EMPTY cycle.
- pip_occupancy_o: EMPTY=0, FULL=1, SKID=2, registered.
- Payload is opaque. No width conversion is done; pip_data_o is bit-identical to the accepted pip_data_i.

Test Plan:
- Reset then stream: rst_i 1->0, then valid_i=1 with data 0x11, 0x22, 0x33 on consecutive cycles and ready_i=1 -> valid_o rises 1 cycle after each accept. data_o shows 0x11, 0x22, 0x33 back-to-back, new_instr_o is high 3 cycles, occupancy stays 1.
- Skid fill (SkidEnable=1): FULL with 0xA0, ready_i=0, valid_i=1 data 0xB0 -> occupancy=2 and ready_o=0 next cycle. Raise ready_i -> outputs 0xA0 then 0xB0, each for one cycle, new_instr_o pulses once per item.
- Downstream stall: item 0x55 held with ready_i=0 for 5 cycles -> data_o=0x55 and valid_o=1 throughout, new_instr_o high only in the first cycle.
- Flush in SKID: occupancy=2, flush_i=1 together with valid_i=1 data 0xCC -> next cycle valid_o=0, data_o=0, occupancy=0, new_instr_o=0, and 0xCC never appears.
- SkidEnable=0: FULL, ready_i=0 -> ready_o=0 in the same cycle. ready_i=1 with valid_i=1 data 0x77 -> pass-through, occupancy never exceeds 1.
- Async reset mid-operation: occupancy=2, assert rst_i between edges -> valid_o, data_o, occupancy and ready_o are all 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/beta_skid_pipe_if.sv
// Handshake bundle between two beta pipeline stages: upstream side, downstream
// side, flush and status. DUT uses slave, the driving stage/bench uses master.
interface beta_skid_pipe_if #(
  parameter int DataWidth = 32
);
  logic                 pip_valid_i;
  logic                 pip_ready_o;
  logic [DataWidth-1:0] pip_data_i;
  logic                 pip_valid_o;
  logic                 pip_ready_i;
  logic [DataWidth-1:0] pip_data_o;
  logic                 pip_flush_i;
  logic                 pip_new_instr_o;
  logic [1:0]           pip_occupancy_o;

  modport slave (
    input  pip_valid_i, pip_data_i, pip_ready_i, pip_flush_i,
    output pip_ready_o, pip_valid_o, pip_data_o, pip_new_instr_o, pip_occupancy_o
  );

  modport master (
    output pip_valid_i, pip_data_i, pip_ready_i, pip_flush_i,
    input  pip_ready_o, pip_valid_o, pip_data_o, pip_new_instr_o, pip_occupancy_o
  );
endinterface

// File: rtl/beta_skid_pipe.sv
// Generic inter-stage register for the beta core: one payload slot plus an
// optional skid entry that keeps pip_ready_o off the downstream ready path.
//
// state    | meaning
// ST_EMPTY | nothing held, data registers are zero
// ST_FULL  | main holds the head item
// ST_SKID  | main holds the head, skid holds the younger item (SkidEnable only)
module beta_skid_pipe #(
  parameter int DataWidth  = 32,
  parameter bit SkidEnable = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  beta_skid_pipe_if.slave pip
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DataWidth-1:0] main_q, main_d;
  logic [DataWidth-1:0] skid_q, skid_d;
  logic                 new_q, new_d;
  logic                 ready_w;
  logic                 in_fire, out_fire;

  // Ready is gated by reset so it drops the moment rst_i rises.
  generate
    if (SkidEnable) begin : g_skid_ready
      assign ready_w = !rst_i && (state_q != ST_SKID);
    end else begin : g_comb_ready
      assign ready_w = !rst_i && ((state_q == ST_EMPTY) || pip.pip_ready_i);
    end
  endgenerate

  assign in_fire  = pip.pip_valid_i && ready_w;
  assign out_fire = (state_q != ST_EMPTY) && pip.pip_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      new_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      new_q   <= new_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    new_d   = 1'b0;
    if (pip.pip_flush_i) begin
      // Flush wins over everything; a same-cycle accept is simply dropped.
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = pip.pip_data_i;
            state_d = ST_FULL;
            new_d   = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = pip.pip_data_i;
            new_d  = 1'b1;
          end else if (in_fire && SkidEnable) begin
            skid_d  = pip.pip_data_i;
            state_d = ST_SKID;
          end else if (out_fire) begin
            main_d  = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_FULL;
            new_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pip.pip_occupancy_o = 2'd0;
    if (state_q == ST_FULL) pip.pip_occupancy_o = 2'd1;
    if (state_q == ST_SKID) pip.pip_occupancy_o = 2'd2;
  end

  assign pip.pip_ready_o     = ready_w;
  assign pip.pip_valid_o     = (state_q != ST_EMPTY);
  assign pip.pip_data_o      = main_q;
  assign pip.pip_new_instr_o = new_q;

endmodule

// File: tb/tb_beta_skid_pipe.sv
// Scoreboard bench: two instances (skid and single-entry) share one stimulus
// stream; each keeps a queue of accepted items as its reference model.
module tb_beta_skid_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v_i = 1'b0;
  logic [31:0] d_i = '0;
  logic        r_i = 1'b0;
  logic        f_i = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [2][$];
  logic        exp_new [2];

  beta_skid_pipe_if #(.DataWidth(32)) bus_s ();
  beta_skid_pipe_if #(.DataWidth(32)) bus_n ();

  beta_skid_pipe #(.DataWidth(32), .SkidEnable(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst), .pip(bus_s)
  );
  beta_skid_pipe #(.DataWidth(32), .SkidEnable(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .pip(bus_n)
  );

  assign bus_s.pip_valid_i = v_i;
  assign bus_s.pip_data_i  = d_i;
  assign bus_s.pip_ready_i = r_i;
  assign bus_s.pip_flush_i = f_i;
  assign bus_n.pip_valid_i = v_i;
  assign bus_n.pip_data_i  = d_i;
  assign bus_n.pip_ready_i = r_i;
  assign bus_n.pip_flush_i = f_i;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Model: queue = accepted, undelivered, unflushed items; a pending accept
  // (pushed by the stimulus before the edge) sits at the tail.
  task automatic mon(input int k, input logic rdy, input logic vld, input logic [31:0] dat,
                     input logic nw, input logic [1:0] occ);
    int   pend, held;
    logic of, nnew;
    pend = (v_i && rdy && !f_i) ? 1 : 0;
    held = exp_q[k].size() - pend;
    chk("occupancy", k, 32'(occ), 32'(held));
    chk("valid_o", k, 32'(vld), 32'(held > 0));
    if (held > 0) chk("data_o", k, dat, exp_q[k][0]);
    else          chk("data_o_empty", k, dat, 32'h0);
    chk("new_instr", k, 32'(nw), 32'(exp_new[k]));
    if (k == 0) chk("ready_o", k, 32'(rdy), 32'(held < 2));
    else        chk("ready_o", k, 32'(rdy), 32'((held == 0) || r_i));
    of = (held > 0) && r_i;
    if (of) void'(exp_q[k].pop_front());
    if (f_i) begin
      exp_q[k].delete();
      nnew = 1'b0;
    end else begin
      nnew = of ? (exp_q[k].size() > 0) : (held == 0 && pend == 1);
    end
    exp_new[k] = nnew;
  endtask

  initial begin
    exp_new[0] = 1'b0;
    exp_new[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q[0].delete();
        exp_q[1].delete();
        exp_new[0] = 1'b0;
        exp_new[1] = 1'b0;
      end else begin
        mon(0, bus_s.pip_ready_o, bus_s.pip_valid_o, bus_s.pip_data_o,
            bus_s.pip_new_instr_o, bus_s.pip_occupancy_o);
        mon(1, bus_n.pip_ready_o, bus_n.pip_valid_o, bus_n.pip_data_o,
            bus_n.pip_new_instr_o, bus_n.pip_occupancy_o);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    v_i = v; d_i = d; r_i = r; f_i = f;
    #2;
    if (!rst && v && !f) begin
      if (bus_s.pip_ready_o) exp_q[0].push_back(d);
      if (bus_n.pip_ready_o) exp_q[1].push_back(d);
    end
  endtask

  task automatic check_reset_now();
    chk("rst_valid", 0, 32'(bus_s.pip_valid_o), 32'h0);
    chk("rst_data", 0, bus_s.pip_data_o, 32'h0);
    chk("rst_occ", 0, 32'(bus_s.pip_occupancy_o), 32'h0);
    chk("rst_ready", 0, 32'(bus_s.pip_ready_o), 32'h0);
    chk("rst_valid", 1, 32'(bus_n.pip_valid_o), 32'h0);
    chk("rst_ready", 1, 32'(bus_n.pip_ready_o), 32'h0);
  endtask

  initial begin
    #2;
    check_reset_now();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // stream
    drive(1, 32'h11, 1, 0);
    drive(1, 32'h22, 1, 0);
    drive(1, 32'h33, 1, 0);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);
    // skid fill and drain
    drive(1, 32'hA0, 0, 0);
    drive(1, 32'hB0, 0, 0);
    drive(0, 32'h0, 0, 0);
    repeat (3) drive(0, 32'h0, 1, 0);
    // downstream stall
    drive(1, 32'h55, 0, 0);
    repeat (5) drive(0, 32'h0, 0, 0);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);
    // flush while two items held, with a competing accept
    drive(1, 32'hA1, 0, 0);
    drive(1, 32'hB1, 0, 0);
    drive(1, 32'hCC, 0, 1);
    drive(0, 32'h0, 1, 0);
    drive(0, 32'h0, 1, 0);
    // single-entry pass-through
    drive(1, 32'h66, 0, 0);
    drive(1, 32'h77, 1, 0);
    drive(0, 32'h0, 1, 0);
    // async reset between edges with two items held
    drive(1, 32'hA2, 0, 0);
    drive(1, 32'hB2, 0, 0);
    drive(0, 32'h0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_now();
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 31) == 0));
    end
    repeat (4) drive(0, 32'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
